// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch buffer: the queued (pc, instr) record and the
// depth used when the buffer is instantiated in the pipeline.
package fetch_buffer_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } FETCH_ENTRY;

  localparam int FETCH_BUF_DEPTH = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched (pc, instr) pairs between programCounter and the
// decoder. A redirect flush empties it in one cycle; status is registered only.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  FETCH_ENTRY          mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic                enq, deq;

  // Ready/valid come from the occupancy register alone, so no out_ready->in_ready path.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_pc    = mem_q[rd_ptr_q].pc;
  assign out_instr = mem_q[rd_ptr_q].instr;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset only; a flush leaves stale data behind the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq && !flush) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue scoreboard on every cycle plus a
// vector table and hand sequences for overflow, streaming, wrap and flush.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_instr, out_instr;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  FETCH_ENTRY exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT against the scoreboard mid-cycle, then advance one edge and
  // update the model from the handshakes that fired on it.
  task automatic tick();
    bit enq, deq;
    if (!rst) begin
      chk("sb_count", 64'(count), 64'(exp_q.size()));
      chk("sb_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("sb_in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        chk("sb_head_pc", out_pc, exp_q[0].pc);
        chk("sb_head_instr", 64'(out_instr), 64'(exp_q[0].instr));
      end
    end
    enq = !rst && !flush && in_valid  && (exp_q.size() != DEPTH);
    deq = !rst && !flush && out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (rst || flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back('{pc: in_pc, instr: in_instr});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic        iv, ordy;
    logic [63:0] pc;
    logic [31:0] ins;
    int          cnt;
    bit          ov, ir, hd;
    logic [63:0] hpc;
    logic [31:0] hins;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic [63:0] pc,
                              input logic [31:0] ins, input int cnt, input bit ov,
                              input bit ir, input bit hd, input logic [63:0] hpc,
                              input logic [31:0] hins);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.pc = pc; v.ins = ins; v.cnt = cnt;
    v.ov = ov; v.ir = ir; v.hd = hd; v.hpc = hpc; v.hins = hins;
    return v;
  endfunction

  vec_t vecs[12];

  task automatic drive(input logic iv, input logic ordy, input logic [63:0] pc);
    in_valid = iv; out_ready = ordy; in_pc = pc; in_instr = ins_of(pc);
  endtask

  initial begin
    // Expected state after each edge: single entry, drain, fill, overflow, drain.
    vecs[0]  = mk(1, 0, 64'h8000_0000, 32'h0010_0093, 1, 1, 1, 1, 64'h8000_0000, 32'h0010_0093);
    vecs[1]  = mk(0, 1, 64'h0,  32'h0,          0, 0, 1, 0, 64'h0,  32'h0);
    vecs[2]  = mk(1, 0, 64'h0,  ins_of(64'h0),  1, 1, 1, 1, 64'h0,  ins_of(64'h0));
    vecs[3]  = mk(1, 0, 64'h4,  ins_of(64'h4),  2, 1, 1, 1, 64'h0,  ins_of(64'h0));
    vecs[4]  = mk(1, 0, 64'h8,  ins_of(64'h8),  3, 1, 1, 1, 64'h0,  ins_of(64'h0));
    vecs[5]  = mk(1, 0, 64'hC,  ins_of(64'hC),  4, 1, 0, 1, 64'h0,  ins_of(64'h0));
    vecs[6]  = mk(1, 0, 64'h10, ins_of(64'h10), 4, 1, 0, 1, 64'h0,  ins_of(64'h0));
    vecs[7]  = mk(1, 1, 64'h10, ins_of(64'h10), 3, 1, 1, 1, 64'h4,  ins_of(64'h4));
    vecs[8]  = mk(1, 1, 64'h10, ins_of(64'h10), 3, 1, 1, 1, 64'h8,  ins_of(64'h8));
    vecs[9]  = mk(0, 1, 64'h0,  32'h0,          2, 1, 1, 1, 64'hC,  ins_of(64'hC));
    vecs[10] = mk(0, 1, 64'h0,  32'h0,          1, 1, 1, 1, 64'h10, ins_of(64'h10));
    vecs[11] = mk(0, 1, 64'h0,  32'h0,          0, 0, 1, 0, 64'h0,  32'h0);

    // Reset with in_valid high: nothing may be enqueued.
    rst = 1; flush = 0;
    drive(1, 0, 64'hDEAD_BEEF);
    tick(); tick();
    rst = 0;
    drive(0, 0, 64'h0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      in_pc = vecs[i].pc; in_instr = vecs[i].ins;
      tick();
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
      if (vecs[i].hd) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].hpc);
        chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].hins));
      end
    end

    // Streaming: one in, one out per cycle, occupancy pinned at 1.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 64'h100 + 64'(4 * i));
      tick();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_pc", out_pc, 64'h100 + 64'(4 * i));
    end
    drive(0, 1, 64'h0);
    tick();
    chk("stream_drain", 64'(count), 64'd0);

    // Wrap-around: 3 in, 3 out, then 4 in so both pointers cross DEPTH.
    for (int i = 0; i < 3; i++) begin drive(1, 0, 64'h400 + 64'(4 * i)); tick(); end
    for (int i = 0; i < 3; i++) begin drive(0, 1, 64'h0); tick(); end
    for (int i = 0; i < 4; i++) begin drive(1, 0, 64'h500 + 64'(4 * i)); tick(); end
    chk("wrap_full", 64'(count), 64'd4);
    chk("wrap_in_ready", 64'(in_ready), 64'd0);
    chk("wrap_head", out_pc, 64'h500);
    for (int i = 0; i < 4; i++) begin drive(0, 1, 64'h0); tick(); end
    chk("wrap_drain", 64'(count), 64'd0);

    // Flush beats a simultaneous enqueue and dequeue.
    for (int i = 0; i < 3; i++) begin drive(1, 0, 64'h300 + 64'(4 * i)); tick(); end
    chk("flush_pre_count", 64'(count), 64'd3);
    flush = 1;
    drive(1, 1, 64'h999);
    tick();
    flush = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drive(1, 0, 64'h200);
    tick();
    chk("post_flush_count", 64'(count), 64'd1);
    chk("post_flush_pc", out_pc, 64'h200);
    chk("post_flush_instr", 64'(out_instr), 64'(ins_of(64'h200)));
    drive(0, 1, 64'h0);
    tick();
    tick();
    chk("final_empty", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
